id_operand_stage: RTL and testbench

//  Decode/operand-fetch stage of the pipelined KGP RISC core. Sits between the IF/ID register and EX.

---
 rtl/kgp_pkg.sv | 32 +++
 rtl/id_operand_stage_operand_mux.sv | 35 +++
 rtl/id_operand_stage.sv | 74 +++++++
 tb/tb_id_operand_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/kgp_pkg.sv
// kgp_pkg: KGP core constants, opcode decode helpers and the ID/EX register layout
package kgp_pkg;
  localparam int XLEN = 32;
  localparam int RADDR_W = 5;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam logic [5:0] OP_LD = 6'b001000;
  localparam logic [5:0] OP_ST = 6'b001001;
  typedef logic [5:0] opcode_t;
  typedef struct packed {
    logic valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [RADDR_W-1:0] dr;
    logic wr_en;
    logic is_load;
    logic fwd1;
    logic fwd2;
  } id_ex_t;
  function automatic opcode_t opcode_of(input logic [XLEN-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction
  // Stores and the 11xxxx branch class are the only non-writing instructions
  function automatic logic writes_reg(input opcode_t op);
    return op != OP_ST && op[5:4] != 2'b11;
  endfunction
  function automatic logic op_is_load(input opcode_t op);
    return op == OP_LD;
  endfunction
endpackage

// File: rtl/id_operand_stage_operand_mux.sv
// operand_mux: hazard compare and MEM/WB forwarding select for one source register.
// WB_BYPASS_EN: when defined a WB match forwards wb_data, otherwise it requests a stall.
module operand_mux
  import kgp_pkg::*;
(
  input  logic [RADDR_W-1:0] src,
  input  logic [XLEN-1:0]    rf_rdata,
  input  logic               ex_valid,
  input  logic               ex_wr_en,
  input  logic               ex_is_load,
  input  logic [RADDR_W-1:0] ex_dr,
  input  logic               mem_wr_en,
  input  logic [RADDR_W-1:0] mem_dr,
  input  logic [XLEN-1:0]    mem_data,
  input  logic               wb_write,
  input  logic [RADDR_W-1:0] wb_dr,
  input  logic [XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]    value,
  output logic               fwd,
  output logic               stall
);
  logic live, ex_hit, mem_hit, wb_hit;
  assign live = src != '0;
  assign ex_hit = live && ex_valid && ex_dr == src;
  assign mem_hit = live && mem_wr_en && mem_dr == src;
  assign wb_hit = live && wb_write && wb_dr == src && !mem_hit;
  // Without bypass a WB hit stalls, so the wb_data picked here is dropped by the bubble
  assign value = mem_hit ? mem_data : wb_hit ? wb_data : rf_rdata;
  assign fwd = ex_hit && ex_wr_en && !ex_is_load;
`ifdef WB_BYPASS_EN
  assign stall = ex_hit && ex_is_load;
`else
  assign stall = (ex_hit && ex_is_load) || wb_hit;
`endif
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: KGP decode/operand fetch with MEM/WB forwarding, hazard stall and the ID/EX register.
// WB_BYPASS_EN selects same-cycle WB forwarding instead of a one-cycle WB stall.
module id_operand_stage
  import kgp_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               if_valid,
  input  logic [XLEN-1:0]    if_instr,
  input  logic [XLEN-1:0]    if_pc,
  input  logic               flush,
  output logic               id_stall,
  output logic [RADDR_W-1:0] rf_sr1,
  output logic [RADDR_W-1:0] rf_sr2,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic [XLEN-1:0]    rf_rdata2,
  input  logic               mem_wr_en,
  input  logic [RADDR_W-1:0] mem_dr,
  input  logic [XLEN-1:0]    mem_data,
  input  logic               wb_write,
  input  logic [RADDR_W-1:0] wb_dr,
  input  logic [XLEN-1:0]    wb_data,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_instr,
  output logic [XLEN-1:0]    ex_op1,
  output logic [XLEN-1:0]    ex_op2,
  output logic [RADDR_W-1:0] ex_dr,
  output logic               ex_wr_en,
  output logic               ex_is_load,
  output logic               ex_fwd1,
  output logic               ex_fwd2
);
  id_ex_t ex, nxt;
  opcode_t opc;
  logic [XLEN-1:0] op1, op2;
  logic fwd1, fwd2, stall1, stall2;
  assign opc = opcode_of(if_instr);
  assign rf_sr1 = if_instr[25:21];
  assign rf_sr2 = if_instr[20:16];
  operand_mux u_src1 (
    .src(rf_sr1), .rf_rdata(rf_rdata1),
    .ex_valid(ex.valid), .ex_wr_en(ex.wr_en), .ex_is_load(ex.is_load), .ex_dr(ex.dr),
    .mem_wr_en(mem_wr_en), .mem_dr(mem_dr), .mem_data(mem_data),
    .wb_write(wb_write), .wb_dr(wb_dr), .wb_data(wb_data),
    .value(op1), .fwd(fwd1), .stall(stall1)
  );
  operand_mux u_src2 (
    .src(rf_sr2), .rf_rdata(rf_rdata2),
    .ex_valid(ex.valid), .ex_wr_en(ex.wr_en), .ex_is_load(ex.is_load), .ex_dr(ex.dr),
    .mem_wr_en(mem_wr_en), .mem_dr(mem_dr), .mem_data(mem_data),
    .wb_write(wb_write), .wb_dr(wb_dr), .wb_data(wb_data),
    .value(op2), .fwd(fwd2), .stall(stall2)
  );
  assign id_stall = if_valid && !flush && (stall1 || stall2);
  always_comb begin
    nxt = '{valid: if_valid, pc: if_pc, instr: if_instr, op1: op1, op2: op2,
            dr: if_instr[25:21], wr_en: writes_reg(opc), is_load: op_is_load(opc),
            fwd1: if_valid && fwd1, fwd2: if_valid && fwd2};
  end
  // Reset, flush and stall all leave an empty ID/EX slot behind
  always_ff @(posedge clk)
    ex <= (reset || flush || id_stall) ? '0 : nxt;
  assign ex_valid = ex.valid;
  assign ex_pc = ex.pc;
  assign ex_instr = ex.instr;
  assign ex_op1 = ex.op1;
  assign ex_op2 = ex.op2;
  assign ex_dr = ex.dr;
  assign ex_wr_en = ex.wr_en;
  assign ex_is_load = ex.is_load;
  assign ex_fwd1 = ex.fwd1;
  assign ex_fwd2 = ex.fwd2;
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: randomized plus directed stimulus; a hazard model predicts each ID/EX slot into a scoreboard.
module tb_id_operand_stage;
  import kgp_pkg::*;
  logic clk = 1'b0;
  logic reset, if_valid, flush, mem_wr_en, wb_write;
  logic [31:0] if_instr, if_pc, rf_rdata1, rf_rdata2, mem_data, wb_data;
  logic [4:0] mem_dr, wb_dr;
  logic id_stall, ex_valid, ex_wr_en, ex_is_load, ex_fwd1, ex_fwd2;
  logic [4:0] rf_sr1, rf_sr2, ex_dr;
  logic [31:0] ex_pc, ex_instr, ex_op1, ex_op2;
  always #5 clk = ~clk;
  id_operand_stage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .id_stall(id_stall), .rf_sr1(rf_sr1), .rf_sr2(rf_sr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .mem_wr_en(mem_wr_en), .mem_dr(mem_dr),
    .mem_data(mem_data), .wb_write(wb_write), .wb_dr(wb_dr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_dr(ex_dr), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_fwd1(ex_fwd1), .ex_fwd2(ex_fwd2)
  );
  typedef struct packed {
    logic rst, bub, v;
    logic [31:0] pc, instr, op1, op2;
    logic [4:0] dr;
    logic wr, ld, f1, f2;
  } rec_t;
  rec_t q[$];
  rec_t e;
  int checks = 0, failures = 0;
  logic m_v = 1'b0, m_wr = 1'b0, m_ld = 1'b0, last_stall = 1'b0;
  logic [4:0] m_dr = 5'd0;
  logic [31:0] ins_h = 32'h0, pc_h = 32'h0;
  logic v_h = 1'b0;
  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", n, a, x, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b);
    return {op, a, b, 16'($urandom)};
  endfunction

  function automatic logic [31:0] rfv(input logic [4:0] s);
    return (s == 5'd0) ? 32'h0 : $urandom;
  endfunction

  // Reference rules for one source against the in-flight EX instruction and the MEM/WB ports
  task automatic src_eval(input logic [4:0] s, input logic [31:0] rf,
                          output logic f, output logic st, output logic [31:0] val);
    logic exm, mm, wm;
    exm = s != 5'd0 && m_v && m_dr == s;
    mm = s != 5'd0 && mem_wr_en && mem_dr == s;
    wm = s != 5'd0 && wb_write && wb_dr == s;
    f = exm && m_wr && !m_ld;
    st = exm && m_ld;
    val = mm ? mem_data : (wm ? wb_data : rf);
`ifndef WB_BYPASS_EN
    if (wm && !mm) st = 1'b1;
`endif
  endtask

  task automatic cycle(input logic rst, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic [31:0] r1, input logic [31:0] r2,
                       input logic mwe, input logic [4:0] mdr, input logic [31:0] md,
                       input logic wwe, input logic [4:0] wdr, input logic [31:0] wd);
    rec_t r;
    logic f1, f2, s1, s2, st;
    logic [31:0] o1, o2;
    logic [5:0] op;
    @(negedge clk);
    reset = rst; if_valid = v; if_instr = ins; if_pc = pc; flush = fl;
    rf_rdata1 = r1; rf_rdata2 = r2; mem_wr_en = mwe; mem_dr = mdr; mem_data = md;
    wb_write = wwe; wb_dr = wdr; wb_data = wd;
    src_eval(ins[25:21], r1, f1, s1, o1);
    src_eval(ins[20:16], r2, f2, s2, o2);
    st = v && !fl && (s1 || s2);
    #1;
    chk("rf_sr1", 32'(rf_sr1), 32'(ins[25:21]));
    chk("rf_sr2", 32'(rf_sr2), 32'(ins[20:16]));
    if (!rst) chk("id_stall", 32'(id_stall), 32'(st));
    op = ins[31:26];
    r = '0;
    r.rst = rst;
    r.bub = rst || fl || st;
    if (!r.bub) begin
      r.v = v; r.pc = pc; r.instr = ins; r.op1 = o1; r.op2 = o2; r.dr = ins[25:21];
      r.wr = op != OP_ST && op[5:4] != 2'b11;
      r.ld = op == OP_LD;
      r.f1 = f1; r.f2 = f2;
    end
    q.push_back(r);
    last_stall = st;
    m_v = r.v; m_dr = r.dr; m_wr = r.wr; m_ld = r.ld;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2, input logic fl, input logic rst,
                       input logic mwe, input logic [4:0] mdr, input logic [31:0] md,
                       input logic wwe, input logic [4:0] wdr, input logic [31:0] wd);
    cycle(rst, 1'b1, ins, $urandom, fl, r1, r2, mwe, mdr, md, wwe, wdr, wd);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("ex_valid", 32'(ex_valid), 32'(e.v));
      if (e.bub) begin
        chk("bubble_fwd1", 32'(ex_fwd1), 32'h0);
        chk("bubble_fwd2", 32'(ex_fwd2), 32'h0);
      end
      if (e.rst) begin
        chk("rst_pc", ex_pc, 32'h0);
        chk("rst_instr", ex_instr, 32'h0);
        chk("rst_op1", ex_op1, 32'h0);
        chk("rst_op2", ex_op2, 32'h0);
        chk("rst_dr", 32'(ex_dr), 32'h0);
        chk("rst_wr_en", 32'(ex_wr_en), 32'h0);
        chk("rst_is_load", 32'(ex_is_load), 32'h0);
      end
      if (e.v) begin
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_instr", ex_instr, e.instr);
        chk("ex_dr", 32'(ex_dr), 32'(e.dr));
        chk("ex_wr_en", 32'(ex_wr_en), 32'(e.wr));
        chk("ex_is_load", 32'(ex_is_load), 32'(e.ld));
        chk("ex_fwd1", 32'(ex_fwd1), 32'(e.f1));
        chk("ex_fwd2", 32'(ex_fwd2), 32'(e.f2));
        if (!e.f1) chk("ex_op1", ex_op1, e.op1);
        if (!e.f2) chk("ex_op2", ex_op2, e.op2);
      end
    end
  end

  initial begin
    logic [31:0] ins;
    logic [5:0] op;
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    idle();
    // ALU RAW at distance one
    issue(mk(ADD, 5'd3, 5'd1), $urandom, $urandom, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    issue(mk(SUB, 5'd3, 5'd2), $urandom, $urandom, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    idle();
    // Load-use: stall, bubble, then MEM forward
    issue(mk(OP_LD, 5'd5, 5'd0), $urandom, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    ins = mk(ADD, 5'd1, 5'd5);
    issue(ins, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    issue(ins, 32'h1, 32'h2, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    idle();
    // WB match: bypass or one-cycle stall
    ins = mk(ADD, 5'd7, 5'd2);
    issue(ins, 32'h11, 32'h3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h55);
    if (last_stall) issue(ins, 32'h55, 32'h3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    idle();
    // r0 never forwards
    issue(mk(ADD, 5'd0, 5'd0), 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h77);
    // Flush during load-use
    issue(mk(OP_LD, 5'd5, 5'd0), $urandom, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    issue(mk(ADD, 5'd5, 5'd1), $urandom, $urandom, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    idle();
    // MEM beats WB
    issue(mk(ADD, 5'd4, 5'd1), 32'h3, $urandom, 1'b0, 1'b0, 1'b1, 5'd4, 32'hA, 1'b1, 5'd4, 32'hB);
    // Reset during a load-use stall
    issue(mk(OP_LD, 5'd5, 5'd0), $urandom, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    ins = mk(ADD, 5'd5, 5'd2);
    issue(ins, 32'h8, 32'h9, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    issue(ins, 32'h8, 32'h9, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 800; i++) begin
      if (!last_stall) begin
        case ($urandom % 4)
          0: op = OP_LD;
          1: op = OP_ST;
          2: op = {2'b11, 4'($urandom)};
          default: op = 6'($urandom_range(0, 47));
        endcase
        ins_h = mk(op, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)));
        pc_h = $urandom;
        v_h = ($urandom % 8) != 0;
      end
      cycle(($urandom % 50) == 0, v_h, ins_h, pc_h, ($urandom % 12) == 0,
            rfv(ins_h[25:21]), rfv(ins_h[20:16]),
            ($urandom % 2) == 0, 5'($urandom_range(0, 5)), $urandom,
            ($urandom % 2) == 0, 5'($urandom_range(0, 5)), $urandom);
    end
    idle();
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drain", q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
